ram_port_arbiter: RTL

- Two-requester arbiter sharing one single-port RAM (DATA_WIDTH x MEM_SIZE, synchronous write, registered read, output gated by output-enable).
- Requester 0 is the image/weight loader. Requester 1 is the convolution engine.
- Burst-locked round-robin: the owning requester holds the port for up to MAX_BURST consecutive accesses, after which ownership passes to the other requester if it is waiting.
- Returns read data to the issuing requester with fixed 1-cycle latency.

---
 rtl/ram_port_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Two-requester arbiter in front of one single-port RAM (synchronous write,
// registered read, output gated by output-enable). Requester 0 is the
// image/weight loader and requester 1 is the convolution engine. Ownership is
// burst-locked round-robin: the owner keeps the port for up to MAX_BURST
// consecutive grants while the other side waits. Read data comes back to the
// issuing requester exactly one cycle after the grant.
//
// Ports
//   RAMARB_Clk, RAMARB_Reset          clock (rising edge), synchronous active-high reset
//   RAMARB_Req/We/Addr/Wdata{0,1}     requester access (held stable until Gnt)
//   RAMARB_Gnt{0,1}                   access accepted this cycle (combinational)
//   RAMARB_Rvalid{0,1}, RAMARB_Rdata  read return, shared data bus
//   RAMARB_RAM_We/Oe/Address/Data_In  RAM control and write path
//   RAMARB_RAM_Data_Out               RAM registered read data
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  RAMARB_Clk,
  input  logic                  RAMARB_Reset,
  input  logic                  RAMARB_Req0,
  input  logic                  RAMARB_Req1,
  input  logic                  RAMARB_We0,
  input  logic                  RAMARB_We1,
  input  logic [ADDR_WIDTH-1:0] RAMARB_Addr0,
  input  logic [ADDR_WIDTH-1:0] RAMARB_Addr1,
  input  logic [DATA_WIDTH-1:0] RAMARB_Wdata0,
  input  logic [DATA_WIDTH-1:0] RAMARB_Wdata1,
  output logic                  RAMARB_Gnt0,
  output logic                  RAMARB_Gnt1,
  output logic                  RAMARB_Rvalid0,
  output logic                  RAMARB_Rvalid1,
  output logic [DATA_WIDTH-1:0] RAMARB_Rdata,
  output logic                  RAMARB_RAM_We,
  output logic                  RAMARB_RAM_Oe,
  output logic [ADDR_WIDTH-1:0] RAMARB_RAM_Address,
  output logic [DATA_WIDTH-1:0] RAMARB_RAM_Data_In,
  input  logic [DATA_WIDTH-1:0] RAMARB_RAM_Data_Out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] MAX_B = CNT_WIDTH'(MAX_BURST);
  localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  bcnt_q, bcnt_d;
  logic                  last_q, last_d;
  logic                  rdpend_q, rdpend_d;
  logic                  rdid_q, rdid_d;

  logic                  gnt0_s, gnt1_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;

  // Grant decision: burst-locked owner, handover once the burst limit is hit
  // and the other side is waiting; from IDLE a tie goes to the non-last owner.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (RAMARB_Req0 && RAMARB_Req1) begin
          if (last_q) begin
            gnt0_s = 1'b1;
          end else begin
            gnt1_s = 1'b1;
          end
        end else begin
          gnt0_s = RAMARB_Req0;
          gnt1_s = RAMARB_Req1;
        end
      end
      ST_OWN0: begin
        if (RAMARB_Req0) begin
          if ((bcnt_q >= MAX_B) && RAMARB_Req1) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b1;
          end
        end else begin
          gnt1_s = RAMARB_Req1;
        end
      end
      ST_OWN1: begin
        if (RAMARB_Req1) begin
          if ((bcnt_q >= MAX_B) && RAMARB_Req0) begin
            gnt0_s = 1'b1;
          end else begin
            gnt1_s = 1'b1;
          end
        end else begin
          gnt0_s = RAMARB_Req0;
        end
      end
      default: begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    endcase
  end

  // Mux of the granted requester onto the RAM path; zero when nobody is granted.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (gnt0_s) begin
      sel_we_s    = RAMARB_We0;
      sel_addr_s  = RAMARB_Addr0;
      sel_wdata_s = RAMARB_Wdata0;
    end else if (gnt1_s) begin
      sel_we_s    = RAMARB_We1;
      sel_addr_s  = RAMARB_Addr1;
      sel_wdata_s = RAMARB_Wdata1;
    end else begin
      sel_we_s    = 1'b0;
    end
  end

  // Next-state: owner, burst count, last owner and the read-return tag.
  always_comb begin
    state_d  = ST_IDLE;
    bcnt_d   = '0;
    last_d   = last_q;
    rdpend_d = (gnt0_s || gnt1_s) && !sel_we_s;
    rdid_d   = gnt1_s;
    if (gnt0_s) begin
      state_d = ST_OWN0;
      if (state_q == ST_OWN0) begin
        // Owner kept the port at the limit only because nobody else waited.
        bcnt_d = (bcnt_q >= MAX_B) ? ONE_C : (bcnt_q + ONE_C);
      end else begin
        bcnt_d = ONE_C;
        last_d = 1'b0;
      end
    end else if (gnt1_s) begin
      state_d = ST_OWN1;
      if (state_q == ST_OWN1) begin
        bcnt_d = (bcnt_q >= MAX_B) ? ONE_C : (bcnt_q + ONE_C);
      end else begin
        bcnt_d = ONE_C;
        last_d = 1'b1;
      end
    end else begin
      state_d = ST_IDLE;
      bcnt_d  = '0;
    end
  end

  // State registers with synchronous reset; reset drops any pending read.
  always_ff @(posedge RAMARB_Clk) begin
    if (RAMARB_Reset) begin
      state_q  <= ST_IDLE;
      bcnt_q   <= '0;
      last_q   <= 1'b1;
      rdpend_q <= 1'b0;
      rdid_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      last_q   <= last_d;
      rdpend_q <= rdpend_d;
      rdid_q   <= rdid_d;
    end
  end

  // Output drive; everything is forced low while reset is held.
  always_comb begin
    RAMARB_Gnt0        = 1'b0;
    RAMARB_Gnt1        = 1'b0;
    RAMARB_RAM_We      = 1'b0;
    RAMARB_RAM_Oe      = 1'b0;
    RAMARB_RAM_Address = '0;
    RAMARB_RAM_Data_In = '0;
    RAMARB_Rvalid0     = 1'b0;
    RAMARB_Rvalid1     = 1'b0;
    RAMARB_Rdata       = '0;
    if (!RAMARB_Reset) begin
      RAMARB_Gnt0        = gnt0_s;
      RAMARB_Gnt1        = gnt1_s;
      RAMARB_RAM_We      = sel_we_s;
      RAMARB_RAM_Address = sel_addr_s;
      RAMARB_RAM_Data_In = sel_wdata_s;
      RAMARB_RAM_Oe      = rdpend_q;
      RAMARB_Rvalid0     = rdpend_q && !rdid_q;
      RAMARB_Rvalid1     = rdpend_q && rdid_q;
      RAMARB_Rdata       = rdpend_q ? RAMARB_RAM_Data_Out : '0;
    end else begin
      RAMARB_Rdata       = '0;
    end
  end

endmodule
